puf_keygen_ctrl: RTL and testbench
==================================

PUF_KEYGEN_CTRL -- requirements
Module: puf_keygen_ctrl

Interface
REQ-001 SHALL have parameter NUM_VOTES, default 3: evaluations per challenge; odd, 1..15.
REQ-002 SHALL have parameter KEY_BYTES, default 4: response bytes per key; 1..8.
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for puf_ready per evaluation.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  request a key generation; sampled in IDLE only.
REQ-007 seed  input  8  base challenge; captured on accepted start.
REQ-008 busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-009 puf_en  output  1  enable to the PUF stage.
REQ-010 puf_chall  output  8  challenge to the PUF stage.
REQ-011 puf_response  input  8  PUF response byte.
REQ-012 puf_ready  input  1  PUF response valid.
REQ-013 key  output  8*KEY_BYTES  assembled key; byte 0 in bits [7:0].
REQ-014 key_valid  output  1  key available.
REQ-015 key_ack  input  1  consumer accepts key.
REQ-016 unstable_cnt  output  8  count of non-unanimous bits in the last key; saturates at 255.
REQ-017 error  output  1  timeout occurred; sticky until the next accepted start or reset.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, GAP, NEXT, DONE, ERR.
REQ-019 IDLE: on start=1, SHALL latch seed, clear byte index, vote index, vote counters, unstable_cnt and error, then go to ISSUE.
REQ-020 ISSUE: SHALL drive puf_en=1 and puf_chall=(seed+byte_index) mod 256, held stable, and SHALL count cycles.
REQ-021 ISSUE: puf_ready=1 SHALL move the FSM to CAPTURE on the next cycle.
REQ-022 ISSUE: if TIMEOUT cycles elapse with no puf_ready, the FSM SHALL go to ERR.
REQ-023 CAPTURE: SHALL add each bit of puf_response to its per-bit ones-counter, which is clog2(NUM_VOTES+1) wide, and drive puf_en=0.
REQ-024 GAP: SHALL hold puf_en=0 for exactly one cycle so the PUF sees an enable edge before the next evaluation.
REQ-025 After GAP, if vote_index < NUM_VOTES-1, SHALL increment vote_index and return to ISSUE; otherwise go to NEXT.
REQ-026 NEXT: SHALL write the byte as bit_i = (ones_i > NUM_VOTES/2) into key[8*byte_index +: 8].
REQ-027 NEXT: SHALL add to unstable_cnt the number of bits with 0 < ones_i < NUM_VOTES, saturating at 255.
REQ-028 NEXT: SHALL clear the counters and vote_index.
REQ-029 NEXT: SHALL go to ISSUE with byte_index+1, or to DONE when the last byte is written.
REQ-030 The challenge SHALL wrap modulo 256; seed=8'hFE with KEY_BYTES=4 gives challenges FE, FF, 00, 01.
REQ-031 DONE: key_valid=1 and key stable until the cycle key_ack=1; the FSM SHALL then return to IDLE, with key_valid low the next cycle.
REQ-032 key_ack outside DONE SHALL be ignored.
REQ-033 start outside IDLE SHALL be ignored, including in DONE.
REQ-034 ERR: error=1 and puf_en=0; the FSM SHALL return to IDLE on the next cycle.
REQ-035 After an error, key SHALL keep its previous contents and key_valid SHALL stay 0.
REQ-036 puf_en SHALL be 1 only in ISSUE.
REQ-037 puf_ready outside ISSUE SHALL be ignored.

Reset
REQ-038 rst=0 at a clock edge SHALL force IDLE and set puf_en=0, puf_chall=0, key=0, key_valid=0, busy=0, error=0 and unstable_cnt=0, clearing all counters and indices.
REQ-039 Reset SHALL take effect in any state, including mid-evaluation and DONE; no key is emitted.

Structure
REQ-040 A shared package puf_pkg SHALL hold the FSM state encoding, PUF_BYTE_W=8 and the default NUM_VOTES, KEY_BYTES and TIMEOUT constants.
REQ-041 One sub-module, puf_vote_acc, SHALL hold the eight per-bit ones-counters and produce the majority byte and the unstable-bit count.

Verification
REQ-042 Behavioural PUF model answering challenge c with ~c after 20 cycles; seed=8'h10, defaults, start -> key=32'hECEDEEEF, key_valid=1, unstable_cnt=0.
REQ-043 Model flipping bit0 on the second vote only, seed=8'h00 -> key byte0 = 8'hFF, unstable_cnt=4 (one unstable bit per byte).
REQ-044 seed=8'hFE -> puf_chall sequence FE, FF, 00, 01, each issued 3 times with one puf_en-low cycle between evaluations.
REQ-045 Model never asserts puf_ready -> error=1 TIMEOUT+1 cycles after ISSUE entry, key_valid stays 0, FSM back in IDLE and a new start is accepted.
REQ-046 rst=0 during the second byte's ISSUE -> next cycle puf_en=0, busy=0, key=0; a subsequent start yields the correct key.
REQ-047 key_ack held low for 50 cycles in DONE -> key_valid and key stay stable and a start pulse during DONE is ignored; key_ack=1 -> IDLE.

Source files
------------

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the PUF key-generation controller:
//   - FSM state encoding (puf_state_t)
//   - PUF_BYTE_W: width of one PUF response / challenge
//   - default NUM_VOTES, KEY_BYTES and TIMEOUT values
//   - sat_add8: saturating add used for the unstable-bit counter
// -----------------------------------------------------------------------------
package puf_pkg;

    localparam int PUF_BYTE_W    = 8;
    localparam int DEF_NUM_VOTES = 3;
    localparam int DEF_KEY_BYTES = 4;
    localparam int DEF_TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_GAP     = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } puf_state_t;

    // 8-bit accumulator plus a 0..8 increment, clamped at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {5'b0_0000, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// -----------------------------------------------------------------------------
// puf_vote_acc
// Eight per-bit ones-counters for majority voting over NUM_VOTES evaluations
// of one PUF response byte.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   clr_i       clear all counters (takes priority over add_i)
//   add_i       accumulate din_i into the counters this cycle
//   din_i       PUF response byte being accumulated
//   maj_o       majority byte: bit i = ones_i > NUM_VOTES/2
//   unstable_o  number of bits with 0 < ones_i < NUM_VOTES (0..8)
// -----------------------------------------------------------------------------
module puf_vote_acc
    import puf_pkg::*;
#(
    parameter int NUM_VOTES = DEF_NUM_VOTES
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  add_i,
    input  logic [PUF_BYTE_W-1:0] din_i,
    output logic [PUF_BYTE_W-1:0] maj_o,
    output logic [3:0]            unstable_o
);

    localparam int              CW   = $clog2(NUM_VOTES + 1);
    localparam logic [CW-1:0]   HALF = CW'(NUM_VOTES / 2);
    localparam logic [CW-1:0]   ALL  = CW'(NUM_VOTES);

    logic [PUF_BYTE_W-1:0] unst_bit;

    genvar gi;
    generate
        for (gi = 0; gi < PUF_BYTE_W; gi++) begin : g_bit
            logic [CW-1:0] ones_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    ones_q <= '0;
                end else if (clr_i) begin
                    ones_q <= '0;
                end else if (add_i) begin
                    ones_q <= ones_q + CW'(din_i[gi]);
                end
            end

            assign maj_o[gi]    = (ones_q > HALF);
            // A bit is unstable when the votes disagree: neither all-0 nor all-1.
            assign unst_bit[gi] = (ones_q != '0) && (ones_q != ALL);
        end
    endgenerate

    always_comb begin
        unstable_o = '0;
        for (int i = 0; i < PUF_BYTE_W; i++) begin
            unstable_o = unstable_o + 4'(unst_bit[i]);
        end
    end

endmodule

// File: rtl/puf_keygen_ctrl.sv
// -----------------------------------------------------------------------------
// puf_keygen_ctrl
// Drives a PUF stage with one challenge per key byte, evaluates each challenge
// NUM_VOTES times, majority-votes every bit and assembles a KEY_BYTES-byte key.
// Counts non-unanimous bits and flags a timeout if the PUF never answers.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-low reset
//   start         request key generation (accepted in IDLE only)
//   seed[7:0]     base challenge, captured on accepted start
//   busy          high from the cycle after accepted start until back in IDLE
//   puf_en        PUF enable, high only while waiting for a response
//   puf_chall     challenge = seed + byte index (mod 256)
//   puf_response  PUF response byte
//   puf_ready     PUF response valid (only looked at while puf_en is high)
//   key           assembled key, byte 0 in bits [7:0]
//   key_valid     key available; held until key_ack
//   key_ack       consumer accepts key (only looked at while key_valid is high)
//   unstable_cnt  non-unanimous bits in the current/last key, saturating
//   error         PUF timeout; sticky until next accepted start or reset
// -----------------------------------------------------------------------------
module puf_keygen_ctrl
    import puf_pkg::*;
#(
    parameter int NUM_VOTES = DEF_NUM_VOTES,
    parameter int KEY_BYTES = DEF_KEY_BYTES,
    parameter int TIMEOUT   = DEF_TIMEOUT
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              seed,
    output logic                    busy,
    output logic                    puf_en,
    output logic [7:0]              puf_chall,
    input  logic [7:0]              puf_response,
    input  logic                    puf_ready,
    output logic [8*KEY_BYTES-1:0]  key,
    output logic                    key_valid,
    input  logic                    key_ack,
    output logic [7:0]              unstable_cnt,
    output logic                    error
);

    localparam int BIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int VIW = (NUM_VOTES > 1) ? $clog2(NUM_VOTES) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [BIW-1:0] LAST_BYTE = BIW'(KEY_BYTES - 1);
    localparam logic [VIW-1:0] LAST_VOTE = VIW'(NUM_VOTES - 1);
    localparam logic [TW-1:0]  TMO_LIM   = TW'(TIMEOUT);

    puf_state_t                state_q;
    logic [7:0]                seed_q;
    logic [BIW-1:0]            byte_idx_q;
    logic [VIW-1:0]            vote_idx_q;
    logic [TW-1:0]             tmo_cnt_q;
    logic [PUF_BYTE_W-1:0]     resp_q;
    logic [PUF_BYTE_W-1:0]     key_build_q [KEY_BYTES];
    logic [8*KEY_BYTES-1:0]    key_q;
    logic                      key_valid_q;
    logic                      busy_q;
    logic                      puf_en_q;
    logic [7:0]                puf_chall_q;
    logic [7:0]                unstable_cnt_q;
    logic                      error_q;

    logic [8*KEY_BYTES-1:0]    key_d;
    logic [7:0]                unstable_cnt_d;
    logic [7:0]                chall_next_d;
    logic                      start_ok;
    logic                      acc_clr;
    logic                      acc_add;
    logic [PUF_BYTE_W-1:0]     acc_maj;
    logic [3:0]                acc_unstable;

    assign start_ok = (state_q == ST_IDLE) && start;
    // Counters are cleared when a run begins and after each byte is consumed.
    assign acc_clr  = start_ok || (state_q == ST_NEXT) || (state_q == ST_ERR);
    assign acc_add  = (state_q == ST_CAPTURE);

    puf_vote_acc #(
        .NUM_VOTES (NUM_VOTES)
    ) u_vote_acc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (acc_clr),
        .add_i      (acc_add),
        .din_i      (resp_q),
        .maj_o      (acc_maj),
        .unstable_o (acc_unstable)
    );

    assign unstable_cnt_d = sat_add8(unstable_cnt_q, acc_unstable);
    assign chall_next_d   = seed_q + 8'(byte_idx_q) + 8'd1;

    // Key as it will look once the byte currently in the accumulator is
    // written. The visible key is only updated from this on entry to DONE,
    // so an aborted run never disturbs the previously delivered key.
    genvar gi;
    generate
        for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key
            assign key_d[8*gi +: 8] = (byte_idx_q == BIW'(gi)) ? acc_maj : key_build_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            seed_q         <= '0;
            byte_idx_q     <= '0;
            vote_idx_q     <= '0;
            tmo_cnt_q      <= '0;
            resp_q         <= '0;
            for (int i = 0; i < KEY_BYTES; i++) begin
                key_build_q[i] <= '0;
            end
            key_q          <= '0;
            key_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            puf_en_q       <= 1'b0;
            puf_chall_q    <= '0;
            unstable_cnt_q <= '0;
            error_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        seed_q         <= seed;
                        byte_idx_q     <= '0;
                        vote_idx_q     <= '0;
                        tmo_cnt_q      <= '0;
                        unstable_cnt_q <= '0;
                        error_q        <= 1'b0;
                        busy_q         <= 1'b1;
                        puf_en_q       <= 1'b1;
                        puf_chall_q    <= seed;
                        state_q        <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (puf_ready) begin
                        // Response is registered here so CAPTURE sees it even
                        // if the PUF drops it once enable falls.
                        resp_q   <= puf_response;
                        puf_en_q <= 1'b0;
                        state_q  <= ST_CAPTURE;
                    end else if (tmo_cnt_q == TMO_LIM) begin
                        puf_en_q <= 1'b0;
                        error_q  <= 1'b1;
                        state_q  <= ST_ERR;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end

                ST_CAPTURE: begin
                    state_q <= ST_GAP;
                end

                ST_GAP: begin
                    if (vote_idx_q == LAST_VOTE) begin
                        state_q <= ST_NEXT;
                    end else begin
                        vote_idx_q <= vote_idx_q + VIW'(1);
                        tmo_cnt_q  <= '0;
                        puf_en_q   <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end

                ST_NEXT: begin
                    key_build_q[byte_idx_q] <= acc_maj;
                    unstable_cnt_q          <= unstable_cnt_d;
                    vote_idx_q              <= '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        key_q       <= key_d;
                        key_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        byte_idx_q  <= byte_idx_q + BIW'(1);
                        tmo_cnt_q   <= '0;
                        puf_chall_q <= chall_next_d;
                        puf_en_q    <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end

                ST_DONE: begin
                    if (key_ack) begin
                        key_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    puf_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign puf_en       = puf_en_q;
    assign puf_chall    = puf_chall_q;
    assign key          = key_q;
    assign key_valid    = key_valid_q;
    assign unstable_cnt = unstable_cnt_q;
    assign error        = error_q;

endmodule

// File: tb/tb_puf_keygen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_keygen_ctrl
// Behavioural PUF (response = ~challenge ^ per-evaluation noise) and a
// reference model that majority-votes the noise table directly.
// -----------------------------------------------------------------------------
module tb_puf_keygen_ctrl;

    localparam int NV  = 3;
    localparam int KB  = 4;
    localparam int TMO = 64;

    logic            clk;
    logic            rst;
    logic            start;
    logic [7:0]      seed;
    logic            busy;
    logic            puf_en;
    logic [7:0]      puf_chall;
    logic [7:0]      puf_response;
    logic            puf_ready;
    logic [8*KB-1:0] key;
    logic            key_valid;
    logic            key_ack;
    logic [7:0]      unstable_cnt;
    logic            error;

    int checks   = 0;
    int failures = 0;

    logic [7:0] noise [0:63];
    logic [7:0] chall_log [$];
    int         model_lat    = 0;
    bit         model_silent = 0;

    puf_keygen_ctrl #(
        .NUM_VOTES (NV),
        .KEY_BYTES (KB),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .busy         (busy),
        .puf_en       (puf_en),
        .puf_chall    (puf_chall),
        .puf_response (puf_response),
        .puf_ready    (puf_ready),
        .key          (key),
        .key_valid    (key_valid),
        .key_ack      (key_ack),
        .unstable_cnt (unstable_cnt),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Behavioural PUF: logs each new evaluation (rising enable), answers after
    // model_lat cycles and holds ready/response until enable drops.
    initial begin
        bit en_prev;
        int wait_cnt;
        int idx;
        en_prev      = 1'b0;
        wait_cnt     = 0;
        puf_ready    = 1'b0;
        puf_response = 8'h00;
        forever begin
            @(negedge clk);
            if (puf_en !== 1'b1) begin
                puf_ready = 1'b0;
                wait_cnt  = 0;
                en_prev   = 1'b0;
            end else begin
                if (!en_prev) begin
                    chall_log.push_back(puf_chall);
                    wait_cnt = 0;
                end
                if (!model_silent && !puf_ready) begin
                    if (wait_cnt >= model_lat) begin
                        idx          = chall_log.size() - 1;
                        if (idx > 63) idx = 63;
                        puf_ready    = 1'b1;
                        puf_response = ~puf_chall ^ noise[idx];
                    end else begin
                        wait_cnt++;
                    end
                end
                en_prev = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 0: no noise, 1: bit0 flipped on the second vote of every byte,
    // 2: sparse random noise.
    task automatic gen_noise(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       noise[i] = 8'h00;
                1:       noise[i] = ((i % NV) == 1) ? 8'h01 : 8'h00;
                default: noise[i] = 8'($urandom) & 8'($urandom);
            endcase
        end
    endtask

    function automatic void model_key(input logic [7:0] s, output logic [8*KB-1:0] k,
                                      output int unst);
        logic [7:0] ch;
        logic [7:0] r;
        int ones;
        k    = '0;
        unst = 0;
        for (int b = 0; b < KB; b++) begin
            ch = s + 8'(b);
            for (int i = 0; i < 8; i++) begin
                ones = 0;
                for (int v = 0; v < NV; v++) begin
                    r = ~ch ^ noise[b*NV + v];
                    ones += int'(r[i]);
                end
                k[8*b + i] = (2 * ones > NV);
                if (ones > 0 && ones < NV) unst++;
            end
        end
        if (unst > 255) unst = 255;
    endfunction

    task automatic pulse_start(input logic [7:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] s, input int lat);
        logic [8*KB-1:0] ek;
        int              eu;
        bit              seen;
        int              n;
        logic [7:0]      ech;
        model_lat    = lat;
        model_silent = 1'b0;
        chall_log.delete();
        pulse_start(s);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_err_clr"}, 64'(error), 64'd0);
        wait_valid(seen);
        chk({tag, "_valid"}, 64'(seen), 64'd1);
        model_key(s, ek, eu);
        chk({tag, "_key"}, 64'(key), 64'(ek));
        chk({tag, "_unst"}, 64'(unstable_cnt), 64'(eu));
        chk({tag, "_nevals"}, 64'(chall_log.size()), 64'(KB*NV));
        n = chall_log.size();
        if (n > KB*NV) n = KB*NV;
        for (int j = 0; j < n; j++) begin
            ech = s + 8'(j / NV);
            chk({tag, "_chall"}, 64'(chall_log[j]), 64'(ech));
        end
        $display("run %s seed=%02h lat=%0d key=%08h unstable=%0d", tag, s, lat, key, unstable_cnt);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk({tag, "_ack_valid"}, 64'(key_valid), 64'd0);
        chk({tag, "_ack_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [8*KB-1:0] prev_key;
        logic [8*KB-1:0] held;
        int              n;
        int              n_log;
        logic [7:0]      s;

        rst     = 1'b0;
        start   = 1'b0;
        seed    = 8'h00;
        key_ack = 1'b0;
        gen_noise(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_puf_en", 64'(puf_en), 64'd0);
        chk("rst_chall", 64'(puf_chall), 64'd0);
        chk("rst_key", 64'(key), 64'd0);
        chk("rst_valid", 64'(key_valid), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_unst", 64'(unstable_cnt), 64'd0);
        rst = 1'b1;
        $display("reset done");

        // Clean PUF, 20-cycle latency.
        gen_noise(0);
        run_and_check("inv", 8'h10, 20);
        chk("inv_const", 64'(key), 64'h0000_0000_ECED_EEEF);
        do_ack("inv");

        // Single flipped bit per byte: majority unaffected, 4 unstable bits.
        gen_noise(1);
        run_and_check("flip", 8'h00, 5);
        chk("flip_byte0", 64'(key[7:0]), 64'hFF);
        chk("flip_unst4", 64'(unstable_cnt), 64'd4);
        do_ack("flip");

        // Challenge wrap.
        gen_noise(0);
        run_and_check("wrap", 8'hFE, 2);
        do_ack("wrap");

        for (int r = 0; r < 6; r++) begin
            gen_noise(2);
            s = 8'($urandom);
            run_and_check("rand", s, int'($urandom_range(0, 25)));
            do_ack("rand");
        end

        // PUF never answers.
        prev_key     = key;
        model_silent = 1'b1;
        chall_log.delete();
        pulse_start(8'h55);
        chk("tmo_en", 64'(puf_en), 64'd1);
        n = 0;
        while (n < TMO + 20 && error !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'(TMO + 1));
        chk("tmo_en_low", 64'(puf_en), 64'd0);
        chk("tmo_key_kept", 64'(key), 64'(prev_key));
        chk("tmo_valid", 64'(key_valid), 64'd0);
        @(negedge clk);
        chk("tmo_idle_busy", 64'(busy), 64'd0);
        chk("tmo_sticky", 64'(error), 64'd1);
        $display("timeout seen after %0d cycles", n);
        gen_noise(2);
        run_and_check("post_tmo", 8'(8'h55 + 8'($urandom_range(0, 7))), 4);
        do_ack("post_tmo");

        // Reset during the second byte's evaluation.
        gen_noise(0);
        model_lat    = 20;
        model_silent = 1'b0;
        chall_log.delete();
        pulse_start(8'h30);
        n = 0;
        while (chall_log.size() < NV + 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached", 64'(chall_log.size() >= NV + 1), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_puf_en", 64'(puf_en), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_key", 64'(key), 64'd0);
        chk("mid_valid", 64'(key_valid), 64'd0);
        $display("mid-run reset applied");
        gen_noise(2);
        run_and_check("post_rst", 8'h30, 3);
        do_ack("post_rst");

        // Hold DONE without ack; a start pulse must be ignored.
        gen_noise(2);
        run_and_check("hold", 8'($urandom), 1);
        held  = key;
        n_log = chall_log.size();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 10) begin
                seed  = 8'hA5;
                start = 1'b1;
            end
            if (c == 11) start = 1'b0;
            chk("hold_valid", 64'(key_valid), 64'd1);
            chk("hold_key", 64'(key), 64'(held));
        end
        start = 1'b0;
        chk("hold_no_eval", 64'(chall_log.size()), 64'(n_log));
        chk("hold_busy", 64'(busy), 64'd1);
        do_ack("hold");
        repeat (3) @(negedge clk);
        chk("hold_idle_en", 64'(puf_en), 64'd0);
        $display("done-hold complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
